// File: rtl/mod_counter.sv
// Up/down modulo counter with synchronous clear/load, wrap or saturate at MAX_VAL,
// combinational terminal-count and a sticky overflow/underflow flag.
module mod_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 255,
  parameter bit          SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;

  // Boundaries come from comparisons, never from a carry-out, so MAX_VAL = 2**WIDTH-1 is safe.
  assign at_max  = (cnt == MAX_C);
  assign at_zero = (cnt == '0);

  assign tc = en & ~clr & ~load & ((dir & at_max) | (~dir & at_zero));

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      cnt_nxt = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (dir) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SAT ? cnt : '0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SAT ? cnt : MAX_C;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three parameterisations share one stimulus;
// directed scenarios use hand-computed values, the random phase uses a reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       en = 1'b0;
  logic       dir = 1'b0;

  logic [7:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: index 0 = defaults, 1 = SAT max 9, 2 = wrap max 9.
  int unsigned m_max [3] = '{255, 9, 9};
  bit          m_sat [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_cnt [3];
  bit          m_ovf [3];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MAX_VAL(255), .SAT(1'b0)) u_def (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .cnt(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .cnt(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .SAT(1'b0)) u_wrp (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .cnt(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_cnt[%0d]", k), cnt_o[k], 0);
      check($sformatf("rst_ovf[%0d]", k), ovf_o[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
    tick();
  endtask

  function automatic bit model_tc(int k);
    return en && !clr && !load &&
           ((dir && m_cnt[k] == m_max[k]) || (!dir && m_cnt[k] == 0));
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end else if (load) begin
        m_cnt[k] = (load_val > m_max[k]) ? m_max[k] : load_val;
      end else if (en) begin
        if (dir && m_cnt[k] == m_max[k]) begin
          m_ovf[k] = 1'b1;
          if (!m_sat[k]) m_cnt[k] = 0;
        end else if (!dir && m_cnt[k] == 0) begin
          m_ovf[k] = 1'b1;
          if (!m_sat[k]) m_cnt[k] = m_max[k];
        end else if (dir) begin
          m_cnt[k] = m_cnt[k] + 1;
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endtask

  initial begin
    tick();

    // Defaults: 260 up-counts wrap once past 255.
    rst_pulse();
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 260; i++) begin
      check($sformatf("up_cnt@%0d", i), cnt_o[0], i % 256);
      check($sformatf("up_tc@%0d", i), tc_o[0], (i % 256 == 255) ? 1 : 0);
      check($sformatf("up_ovf@%0d", i), ovf_o[0], (i >= 256) ? 1 : 0);
      tick();
    end
    check("up_cnt_end", cnt_o[0], 4);

    // Saturate mode, MAX_VAL = 9: climb and hold, then descend and hold.
    en = 1'b0;
    rst_pulse();
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("sat_up_cnt@%0d", i), cnt_o[1], (i < 9) ? i : 9);
      check($sformatf("sat_up_ovf@%0d", i), ovf_o[1], (i >= 10) ? 1 : 0);
    end
    check("sat_up_tc", tc_o[1], 1);
    dir = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("sat_dn_cnt@%0d", i), cnt_o[1], (i < 9) ? 9 - i : 0);
      check($sformatf("sat_dn_ovf@%0d", i), ovf_o[1], 1);
    end

    // Load clamp, wrap sets ovf, then clr beats load and en.
    en = 1'b0;
    rst_pulse();
    load = 1'b1; load_val = 8'd200;
    tick();
    check("ld_clamp_wrp", cnt_o[2], 9);
    check("ld_clamp_sat", cnt_o[1], 9);
    check("ld_def", cnt_o[0], 200);
    check("ld_ovf", ovf_o[2], 0);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #1 check("wrp_tc_max", tc_o[2], 1);
    tick();
    check("wrp_up_cnt", cnt_o[2], 0);
    check("wrp_up_ovf", ovf_o[2], 1);
    clr = 1'b1; load = 1'b1; load_val = 8'd5;
    #1 check("clr_masks_tc", tc_o[0], 0);
    tick();
    check("clr_all_cnt", cnt_o[2], 0);
    check("clr_all_ovf", ovf_o[2], 0);
    check("clr_all_def", cnt_o[0], 0);

    // Wrap-mode underflow at 0, then an immediate direction change.
    clr = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b0;
    #1 check("dn_tc_zero", tc_o[2], 1);
    tick();
    check("dn_wrap_cnt", cnt_o[2], 9);
    check("dn_wrap_ovf", ovf_o[2], 1);
    dir = 1'b1;
    tick();
    check("dir_flip_cnt", cnt_o[2], 0);
    dir = 1'b0;
    tick();
    check("dir_flip2_cnt", cnt_o[2], 9);

    // Asynchronous reset mid-cycle discards count and ovf.
    en = 1'b0;
    rst_pulse();
    en = 1'b1; dir = 1'b0;
    tick();
    check("pre_rst_cnt", cnt_o[0], 255);
    en = 1'b0; load = 1'b1; load_val = 8'd57;
    tick();
    load = 1'b0;
    check("pre_rst_57", cnt_o[0], 57);
    check("pre_rst_ovf", ovf_o[0], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt", cnt_o[0], 0);
    check("async_rst_ovf", ovf_o[0], 0);
    en = 1'b1; dir = 1'b0; load = 1'b1; load_val = 8'd33;
    #1 check("rst_tc", tc_o[0], 0);
    load = 1'b0;
    #1 check("rst_tc_dn", tc_o[0], 1);
    load = 1'b1;
    tick();
    check("rst_override", cnt_o[0], 0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    check("post_rst_cnt", cnt_o[0], 1);
    check("post_rst_ovf", ovf_o[0], 0);

    // Random phase against the model.
    en = 1'b0;
    rst_pulse();
    for (int i = 0; i < 2000; i++) begin
      clr      = ($urandom_range(15) == 0);
      load     = ($urandom_range(7) == 0);
      en       = ($urandom_range(3) != 0);
      dir      = $urandom_range(1);
      load_val = 8'($urandom_range(255));
      #1;
      for (int k = 0; k < 3; k++)
        check($sformatf("rnd_tc[%0d]@%0d", k, i), tc_o[k], model_tc(k));
      model_step();
      tick();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd_cnt[%0d]@%0d", k, i), cnt_o[k], m_cnt[k]);
        check($sformatf("rnd_ovf[%0d]@%0d", k, i), ovf_o[k], m_ovf[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
